// File: rtl/axi_rd_arb_pkg.sv
// rtl/axi_rd_arb_pkg.sv - shared AXI constants, owner IDs and FSM encoding for the read arbiter
package axi_rd_arb_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int ID_IC = 0;
  localparam int ID_DC = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

endpackage

// File: rtl/axi_rd_arb_rr_arb2.sv
// rtl/axi_rd_arb_rr_arb2.sv - 2-way picker (bit0 ic, bit1 dc); round-robin under AXI_RD_ARB_RR_EN, else dc priority
module axi_rd_arb_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_dc,
  output logic [1:0] gnt
);

`ifdef AXI_RD_ARB_RR_EN
  // Tie goes to whichever port did not win the previous grant.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_dc ? 2'b01 : 2'b10;
  end
`else
  logic unused_last_dc;
  assign unused_last_dc = last_dc;

  // Tie always goes to the data side to keep load-use latency low.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = 2'b10;
  end
`endif

endmodule

// File: rtl/axi_rd_arb.sv
// rtl/axi_rd_arb.sv - single-outstanding AXI read arbiter between icache and data side (AXI_RD_ARB_RR_EN selects round-robin)
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int IC_LEN = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic              ic_rvalid,
  output logic              ic_rlast,
  output logic              ic_rerr,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [7:0]        dc_len,
  output logic              dc_ack,
  output logic              dc_rvalid,
  output logic              dc_rlast,
  output logic              dc_rerr,
  output logic [DATA_W-1:0] rdata_o,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  state_t            state, state_nxt;
  logic [1:0]        gnt;
  logic              last_dc;
  logic              owner_dc;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [ID_W-1:0]   arid_q;
  logic [7:0]        beat_cnt;
  logic              beat;
  logic              beat_err;
  logic [ID_W-1:0]   owner_id;

  axi_rd_arb_rr_arb2 u_arb (
    .req     ({dc_req, ic_req}),
    .last_dc (last_dc),
    .gnt     (gnt)
  );

  assign arsize   = 3'($clog2(DATA_W / 8));
  assign arburst  = AXI_BURST_INCR;
  assign araddr   = araddr_q;
  assign arlen    = arlen_q;
  assign arid     = arid_q;
  assign rdata_o  = rdata;
  assign owner_id = owner_dc ? ID_W'(ID_DC) : ID_W'(ID_IC);
  assign beat     = (state == ST_R) && rvalid;
  assign beat_err = (rresp != AXI_RESP_OKAY) || (rid != owner_id) ||
                    (rlast && (beat_cnt != arlen_q));

  assign ic_rvalid = beat && !owner_dc;
  assign ic_rlast  = ic_rvalid && rlast;
  assign ic_rerr   = ic_rvalid && beat_err;
  assign dc_rvalid = beat && owner_dc;
  assign dc_rlast  = dc_rvalid && rlast;
  assign dc_rerr   = dc_rvalid && beat_err;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs; acks only ever pulse from IDLE.
  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ic_ack    = 1'b0;
    dc_ack    = 1'b0;
    case (state)
      ST_IDLE: begin
        ic_ack = gnt[0];
        dc_ack = gnt[1];
        if (|gnt) state_nxt = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's AR fields at grant and count R beats of the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      owner_dc <= 1'b0;
      last_dc  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (state == ST_IDLE && |gnt) begin
        araddr_q <= gnt[1] ? dc_addr : ic_addr;
        arlen_q  <= gnt[1] ? dc_len : 8'(IC_LEN);
        arid_q   <= gnt[1] ? ID_W'(ID_DC) : ID_W'(ID_IC);
        owner_dc <= gnt[1];
        last_dc  <= gnt[1];
      end
      if (state == ST_AR && arready) beat_cnt <= '0;
      else if (beat)                 beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb/tb_axi_rd_arb.sv - directed scoreboard bench for axi_rd_arb (honours AXI_RD_ARB_RR_EN)
module tb_axi_rd_arb;

`ifdef AXI_RD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, dc_req;
  logic [31:0] ic_addr, dc_addr;
  logic [7:0]  dc_len;
  logic        ic_ack, ic_rvalid, ic_rlast, ic_rerr;
  logic        dc_ack, dc_rvalid, dc_rlast, dc_rerr;
  logic [31:0] rdata_o;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        dc;
  } ar_t;

  typedef struct packed {
    logic        dc;
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  ar_t   ar_q[$];
  beat_t sb_q[$];

  int   checks = 0;
  int   errors = 0;
  bit   last_dc_m = 1'b0;
  bit   cur_dc = 1'b0;
  int   cur_len = 0;
  int   beat_idx = 0;

  axi_rd_arb dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ack    (ic_ack),
    .ic_rvalid (ic_rvalid),
    .ic_rlast  (ic_rlast),
    .ic_rerr   (ic_rerr),
    .dc_req    (dc_req),
    .dc_addr   (dc_addr),
    .dc_len    (dc_len),
    .dc_ack    (dc_ack),
    .dc_rvalid (dc_rvalid),
    .dc_rlast  (dc_rlast),
    .dc_rerr   (dc_rerr),
    .rdata_o   (rdata_o),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .arid      (arid),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rid       (rid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with reqs already driven in an IDLE cycle: check ack, record expected AR.
  task automatic arb_step();
    bit  w_dc;
    ar_t e;
    if (ic_req && dc_req) w_dc = RR ? !last_dc_m : 1'b1;
    else                  w_dc = dc_req;
    #1;
    check("ic_ack", {31'b0, ic_ack}, {31'b0, !w_dc});
    check("dc_ack", {31'b0, dc_ack}, {31'b0, w_dc});
    e.addr = w_dc ? dc_addr : ic_addr;
    e.len  = w_dc ? dc_len : 8'd3;
    e.dc   = w_dc;
    ar_q.push_back(e);
    last_dc_m = w_dc;
    tick();
    if (w_dc) dc_req = 1'b0;
    else      ic_req = 1'b0;
    #1;
    check("ack_once", {30'b0, ic_ack, dc_ack}, 32'h0);
    check("arvalid_after_req", {31'b0, arvalid}, 32'h1);
  endtask

  task automatic serve_ar(input int hold);
    int  budget;
    ar_t e;
    budget = 0;
    while (arvalid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    check("ar_wait", {31'b0, arvalid}, 32'h1);
    if (ar_q.size() == 0) begin
      check("ar_queue_empty", 32'h1, 32'h0);
      return;
    end
    e = ar_q[0];
    for (int i = 0; i < hold; i++) begin
      check("ar_hold_valid", {31'b0, arvalid}, 32'h1);
      check("ar_hold_addr", araddr, e.addr);
      check("ar_hold_len", {24'b0, arlen}, {24'b0, e.len});
      check("ar_hold_noack", {30'b0, ic_ack, dc_ack}, 32'h0);
      tick();
    end
    arready = 1'b1;
    #1;
    e = ar_q.pop_front();
    check("araddr", araddr, e.addr);
    check("arlen", {24'b0, arlen}, {24'b0, e.len});
    check("arid", {28'b0, arid}, {31'b0, e.dc});
    cur_dc   = e.dc;
    cur_len  = int'(e.len);
    beat_idx = 0;
    tick();
    arready = 1'b0;
    #1;
    check("r_phase", {30'b0, rready, arvalid}, 32'h2);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [1:0] resp,
                           input logic last, input logic bad_id);
    beat_t e;
    beat_t p;
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    rlast  = last;
    rid    = bad_id ? 4'hf : {3'b0, cur_dc};
    e.dc   = cur_dc;
    e.data = data;
    e.last = last;
    e.err  = (resp != 2'b00) || bad_id || (last && beat_idx != cur_len);
    sb_q.push_back(e);
    #1;
    p = sb_q.pop_front();
    check("ic_beat", {29'b0, ic_rvalid, ic_rlast, ic_rerr},
          p.dc ? 32'h0 : {29'b0, 1'b1, p.last, p.err});
    check("dc_beat", {29'b0, dc_rvalid, dc_rlast, dc_rerr},
          p.dc ? {29'b0, 1'b1, p.last, p.err} : 32'h0);
    check("rdata_o", rdata_o, p.data);
    beat_idx++;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    if (last) check("idle_after_last", {30'b0, rready, arvalid}, 32'h0);
  endtask

  task automatic run_burst(input logic [31:0] base);
    for (int i = 0; i <= cur_len; i++)
      send_beat(base + 32'(i), 2'b00, i == cur_len, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    ic_req  = 1'b0;
    dc_req  = 1'b0;
    ic_addr = '0;
    dc_addr = '0;
    dc_len  = '0;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rdata   = '0;
    rresp   = 2'b00;
    rid     = '0;
    tick();
    tick();
    check("rst_ctrl", {25'b0, arvalid, rready, ic_ack, dc_ack, ic_rvalid, dc_rvalid, ic_rerr},
          32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_arlen_arid", {20'b0, arlen, arid}, 32'h0);
    check("arsize_arburst", {27'b0, arsize, arburst}, {27'b0, 3'd2, 2'b01});
    reset = 1'b0;
    tick();

    // 1: icache refill, arready one cycle late, 4 beats
    ic_addr = 32'h1c000040;
    ic_req  = 1'b1;
    arb_step();
    serve_ar(1);
    run_burst(32'ha0000000);
    tick();

    // 2: uncached single-beat load
    dc_addr = 32'hbfaf8000;
    dc_len  = 8'd0;
    dc_req  = 1'b1;
    arb_step();
    serve_ar(0);
    run_burst(32'hd00d0001);
    tick();

    // 3: simultaneous requests twice in a row, loser held until served
    ic_addr = 32'h1c000080;
    dc_addr = 32'h80000100;
    dc_len  = 8'd1;
    ic_req  = 1'b1;
    dc_req  = 1'b1;
    arb_step();
    serve_ar(0);
    run_burst(32'h30000000);
    dc_addr = 32'h80000200;
    dc_req  = 1'b1;
    arb_step();
    serve_ar(0);
    run_burst(32'h31000000);
    for (int n = 0; n < 2 && (ic_req || dc_req); n++) begin
      arb_step();
      serve_ar(0);
      run_burst(32'h32000000 + 32'(n << 8));
    end
    tick();

    // 4: AR held off for 5 cycles
    dc_addr = 32'h80001000;
    dc_len  = 8'd1;
    dc_req  = 1'b1;
    arb_step();
    serve_ar(5);
    run_burst(32'h40000000);
    tick();

    // 5a: SLVERR on beat 2, burst continues to rlast
    ic_addr = 32'h1c0000c0;
    ic_req  = 1'b1;
    arb_step();
    serve_ar(0);
    send_beat(32'h50000000, 2'b00, 1'b0, 1'b0);
    send_beat(32'h50000001, 2'b10, 1'b0, 1'b0);
    send_beat(32'h50000002, 2'b00, 1'b0, 1'b0);
    send_beat(32'h50000003, 2'b00, 1'b1, 1'b0);
    tick();

    // 5b: early rlast on beat 2 of a 4-beat burst
    ic_addr = 32'h1c000100;
    ic_req  = 1'b1;
    arb_step();
    serve_ar(0);
    send_beat(32'h51000000, 2'b00, 1'b0, 1'b0);
    send_beat(32'h51000001, 2'b00, 1'b1, 1'b0);
    tick();

    // 6: reset in the middle of the R phase, then a normal transaction
    ic_addr = 32'h1c000140;
    ic_req  = 1'b1;
    arb_step();
    serve_ar(0);
    send_beat(32'h60000000, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_idle", {28'b0, arvalid, rready, ic_rvalid, ic_ack}, 32'h0);
    tick();
    reset = 1'b0;
    last_dc_m = 1'b0;
    check("midrst_after", {30'b0, arvalid, rready}, 32'h0);
    dc_addr = 32'h80002000;
    dc_len  = 8'd0;
    dc_req  = 1'b1;
    arb_step();
    serve_ar(0);
    run_burst(32'h61000000);
    tick();

    // 7: rid mismatch flags the beat
    dc_addr = 32'h80003000;
    dc_len  = 8'd0;
    dc_req  = 1'b1;
    arb_step();
    serve_ar(0);
    send_beat(32'h70000000, 2'b00, 1'b1, 1'b1);
    tick();

    check("scoreboard_drained", 32'(ar_q.size() + sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
